// File: rtl/lfsr.sv
// Parameterised Fibonacci/Galois LFSR with optional de Bruijn extension that
// inserts the all-zero state into the cycle.
module lfsr #(
   parameter int unsigned       LENGTH = 8,
   parameter logic [0:LENGTH-1] TAPS   = 8'b01110001,
   parameter int unsigned       TYPE   = 0,
   parameter int unsigned       EXTEND = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [0:LENGTH-1] seed,
   output logic [0:LENGTH-1] data,
   output logic              previous_msb
);

   localparam int unsigned MSB = LENGTH - 1;

   logic [0:LENGTH-1] data_q;
   logic [0:LENGTH-1] data_d;
   logic              previous_msb_q;
   logic              previous_msb_d;
   logic [0:LENGTH-1] step_c;
   logic [0:LENGTH-1] load_c;
   logic              zero_c;
   logic              ext_z_c;

   // z flags the state just before (or at) the all-zero point of the cycle
   always_comb begin
      zero_c  = ~|data_q[0:MSB-1];
      ext_z_c = (EXTEND != 0) & zero_c;
   end

   if (TYPE == 0) begin : g_fib
      logic fb_c;

      always_comb begin
         fb_c   = (^(data_q & TAPS)) ^ ext_z_c;
         step_c = {fb_c, data_q[0:MSB-1]};
      end
   end else begin : g_gal
      logic out_c;

      always_comb begin
         out_c  = data_q[MSB] ^ ext_z_c;
         step_c = {out_c, data_q[0:MSB-1] ^ (TAPS[1:MSB] & {(LENGTH-1){out_c}})};
      end
   end

   // A zero seed would lock up the conventional sequence, so substitute 1
   always_comb begin
      load_c = seed;
      if ((EXTEND == 0) && (seed == '0)) begin
         load_c = LENGTH'(1);
      end
   end

   always_comb begin
      data_d         = data_q;
      previous_msb_d = previous_msb_q;
      if (enable) begin
         data_d         = step_c;
         previous_msb_d = data_q[MSB];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q         <= load_c;
         previous_msb_q <= 1'b0;
      end else begin
         data_q         <= data_d;
         previous_msb_q <= previous_msb_d;
      end
   end

   assign data         = data_q;
   assign previous_msb = previous_msb_q;

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: five instances (Fibonacci/Galois, plain/extended)
// share one stimulus stream and are checked against hand-computed states.
module tb_lfsr;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [0:7] seed;

   logic [0:7] d_fib0, d_fib1, d_gal0, d_galm0, d_galm1;
   logic       p_fib0, p_fib1, p_gal0, p_galm0, p_galm1;

   int n_cmp;
   int n_bad;

   lfsr #(.LENGTH(8), .TAPS(8'b01110001), .TYPE(0), .EXTEND(0)) u_fib0 (
      .clk(clk), .rst(rst), .enable(enable), .seed(seed),
      .data(d_fib0), .previous_msb(p_fib0));

   lfsr #(.LENGTH(8), .TAPS(8'b01110001), .TYPE(0), .EXTEND(1)) u_fib1 (
      .clk(clk), .rst(rst), .enable(enable), .seed(seed),
      .data(d_fib1), .previous_msb(p_fib1));

   lfsr #(.LENGTH(8), .TAPS(8'b01110000), .TYPE(1), .EXTEND(0)) u_gal0 (
      .clk(clk), .rst(rst), .enable(enable), .seed(seed),
      .data(d_gal0), .previous_msb(p_gal0));

   // x^8+x^4+x^3+x^2+1: maximal in Galois form
   lfsr #(.LENGTH(8), .TAPS(8'b00111000), .TYPE(1), .EXTEND(0)) u_galm0 (
      .clk(clk), .rst(rst), .enable(enable), .seed(seed),
      .data(d_galm0), .previous_msb(p_galm0));

   lfsr #(.LENGTH(8), .TAPS(8'b00111000), .TYPE(1), .EXTEND(1)) u_galm1 (
      .clk(clk), .rst(rst), .enable(enable), .seed(seed),
      .data(d_galm1), .previous_msb(p_galm1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] get_data(int k);
      case (k)
         0:       return d_fib0;
         1:       return d_fib1;
         2:       return d_galm0;
         default: return d_galm1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [7:0] s);
      seed = s;
      rst  = 1'b1;
      tick();
      rst  = 1'b0;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      do_reset(8'h5A);
      n_cmp++;
      if (d_fib0 !== 8'h5A) begin
         n_bad++; $display("FAIL reset_fib0_data: got %h expected 5a", d_fib0);
      end
      n_cmp++;
      if (d_galm1 !== 8'h5A) begin
         n_bad++; $display("FAIL reset_galm1_data: got %h expected 5a", d_galm1);
      end
      n_cmp++;
      if ({p_fib0, p_fib1, p_gal0, p_galm0, p_galm1} !== 5'b0) begin
         n_bad++; $display("FAIL reset_prev_msb: got %b expected 00000",
                           {p_fib0, p_fib1, p_gal0, p_galm0, p_galm1});
      end
   endtask

   task automatic test_hold();
      int bad_cycles;
      enable = 1'b0;
      do_reset(8'h5A);
      bad_cycles = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (d_fib0 !== 8'h5A || d_gal0 !== 8'h5A || p_fib0 !== 1'b0 || p_gal0 !== 1'b0)
            bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles !== 0) begin
         n_bad++; $display("FAIL hold_50: %0d cycles moved, expected 0 (last fib0=%h prev=%b)",
                           bad_cycles, d_fib0, p_fib0);
      end
   endtask

   task automatic test_fib_seq();
      logic [7:0] exp_d [5] = '{8'h80, 8'h40, 8'hA0, 8'hD0, 8'h68};
      logic       exp_p [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      enable = 1'b0;
      do_reset(8'h01);
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (d_fib0 !== exp_d[i] || p_fib0 !== exp_p[i]) begin
            n_bad++; $display("FAIL fib_step%0d: got %h/%b expected %h/%b",
                              i, d_fib0, p_fib0, exp_d[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_gal_seq();
      logic [7:0] exp_d [3] = '{8'hF0, 8'h78, 8'h3C};
      logic       exp_p [3] = '{1'b1, 1'b0, 1'b0};
      enable = 1'b0;
      do_reset(8'h01);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (d_gal0 !== exp_d[i] || p_gal0 !== exp_p[i]) begin
            n_bad++; $display("FAIL gal_step%0d: got %h/%b expected %h/%b",
                              i, d_gal0, p_gal0, exp_d[i], exp_p[i]);
         end
      end
   endtask

   task automatic test_extended_seq();
      enable = 1'b0;
      do_reset(8'h01);
      enable = 1'b1;
      tick();
      n_cmp++;
      if (d_fib1 !== 8'h00 || p_fib1 !== 1'b1) begin
         n_bad++; $display("FAIL ext_fib_step0: got %h/%b expected 00/1", d_fib1, p_fib1);
      end
      n_cmp++;
      if (d_galm1 !== 8'h00 || p_galm1 !== 1'b1) begin
         n_bad++; $display("FAIL ext_gal_step0: got %h/%b expected 00/1", d_galm1, p_galm1);
      end
      tick();
      n_cmp++;
      if (d_fib1 !== 8'h80 || p_fib1 !== 1'b0) begin
         n_bad++; $display("FAIL ext_fib_step1: got %h/%b expected 80/0", d_fib1, p_fib1);
      end
      n_cmp++;
      if (d_galm1 !== 8'hB8 || p_galm1 !== 1'b0) begin
         n_bad++; $display("FAIL ext_gal_step1: got %h/%b expected b8/0", d_galm1, p_galm1);
      end
   endtask

   task automatic test_zero_seed();
      enable = 1'b0;
      do_reset(8'h00);
      n_cmp++;
      if (d_fib0 !== 8'h01 || d_gal0 !== 8'h01) begin
         n_bad++; $display("FAIL zero_seed_plain: got %h,%h expected 01,01", d_fib0, d_gal0);
      end
      n_cmp++;
      if (d_fib1 !== 8'h00 || d_galm1 !== 8'h00) begin
         n_bad++; $display("FAIL zero_seed_ext: got %h,%h expected 00,00", d_fib1, d_galm1);
      end
   endtask

   task automatic test_mid_reset();
      enable = 1'b0;
      do_reset(8'h01);
      enable = 1'b1;
      tick();
      n_cmp++;
      if (d_fib0 !== 8'h80 || p_fib0 !== 1'b1) begin
         n_bad++; $display("FAIL mid_pre: got %h/%b expected 80/1", d_fib0, p_fib0);
      end
      // one-cycle pause mid-run holds the state
      enable = 1'b0;
      tick();
      n_cmp++;
      if (d_fib0 !== 8'h80 || p_fib0 !== 1'b1) begin
         n_bad++; $display("FAIL mid_pause: got %h/%b expected 80/1", d_fib0, p_fib0);
      end
      enable = 1'b1;
      do_reset(8'hC3);
      n_cmp++;
      if (d_fib0 !== 8'hC3 || p_fib0 !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset: got %h/%b expected c3/0", d_fib0, p_fib0);
      end
      tick();
      n_cmp++;
      if (d_fib0 !== 8'h61 || p_fib0 !== 1'b1) begin
         n_bad++; $display("FAIL mid_resume: got %h/%b expected 61/1", d_fib0, p_fib0);
      end
   endtask

   task automatic test_period();
      bit         seen   [4][256];
      int         period [4];
      bit         dup    [4];
      bit         zseen  [4];
      int         exp_p  [4] = '{255, 256, 255, 256};
      logic [7:0] v;
      for (int k = 0; k < 4; k++) begin
         period[k] = 0; dup[k] = 1'b0; zseen[k] = 1'b0;
         for (int j = 0; j < 256; j++) seen[k][j] = 1'b0;
         seen[k][1] = 1'b1;
      end
      enable = 1'b0;
      do_reset(8'h01);
      enable = 1'b1;
      for (int s = 1; s <= 300; s++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            if (period[k] == 0) begin
               v = get_data(k);
               if (v === 8'h01) period[k] = s;
               else begin
                  if (seen[k][v]) dup[k] = 1'b1;
                  seen[k][v] = 1'b1;
                  if (v === 8'h00) zseen[k] = 1'b1;
               end
            end
         end
         if (period[0] != 0 && period[1] != 0 && period[2] != 0 && period[3] != 0) break;
      end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (period[k] !== exp_p[k]) begin
            n_bad++; $display("FAIL period%0d: got %0d expected %0d (0 = no return)",
                              k, period[k], exp_p[k]);
         end
         n_cmp++;
         if (dup[k] !== 1'b0) begin
            n_bad++; $display("FAIL distinct%0d: repeated state seen, expected none", k);
         end
      end
      n_cmp++;
      if (zseen[0] !== 1'b0 || zseen[2] !== 1'b0) begin
         n_bad++; $display("FAIL no_zero_plain: zero seen fib=%b gal=%b expected 0/0",
                           zseen[0], zseen[2]);
      end
      n_cmp++;
      if (zseen[1] !== 1'b1 || zseen[3] !== 1'b1) begin
         n_bad++; $display("FAIL zero_in_ext: zero seen fib=%b gal=%b expected 1/1",
                           zseen[1], zseen[3]);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst    = 1'b0;
      enable = 1'b0;
      seed   = 8'h00;
      tick();
      test_reset();
      test_hold();
      test_fib_seq();
      test_gal_seq();
      test_extended_seq();
      test_zero_seed();
      test_mid_reset();
      test_period();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
